// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch unit: FSM encoding,
// buffer entry layout and the 65-bit bounds helper.
package fetch_pkg;

    typedef enum logic [1:0] {
        FETCH         = 2'd0,
        HALT_END      = 2'd1,
        HALT_MISALIGN = 2'd2
    } state_t;

    localparam int INST_BYTES = 4;
    localparam int ENTRY_W    = 96;

    typedef struct packed {
        logic [31:0] inst;
        logic [63:0] pc;
    } entry_t;

    // Widened by one bit so an address near 2^64 cannot wrap into range
    function automatic logic fits(
        input logic [63:0] addr,
        input logic [64:0] span,
        input logic [64:0] lim
    );
        return ({1'b0, addr} + span) <= lim;
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Instruction-memory, decode and redirect signals of the fetch unit.
// master is the fetch side; slave is memory/decode/execute.
interface instruction_fetch_unit_if;

    logic [63:0] Inst_Address;
    logic [31:0] Instruction;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_out;
    logic [63:0] inst_pc;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        fetch_halted;
    logic        misaligned;

    modport master (
        output Inst_Address,
        input  Instruction,
        output inst_valid,
        input  inst_ready,
        output inst_out,
        output inst_pc,
        input  redirect_valid,
        input  redirect_pc,
        output fetch_halted,
        output misaligned
    );

    modport slave (
        input  Inst_Address,
        output Instruction,
        input  inst_valid,
        output inst_ready,
        input  inst_out,
        input  inst_pc,
        output redirect_valid,
        output redirect_pc,
        input  fetch_halted,
        input  misaligned
    );

endinterface

// File: rtl/fetch_buffer.sv
// Small FIFO of {inst, pc} entries between fetch and decode.
// Flush wins over push and pop; push+pop at full is allowed.
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  entry_t        din,
    output entry_t        dout,
    output logic [CW-1:0] count
);

    localparam int AW = $clog2(DEPTH);

    entry_t        mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_pop;
    logic          do_push;
    logic          not_full;

    assign not_full = count < CW'(DEPTH);
    assign do_pop   = pop & (count != '0);
    assign do_push  = push & (not_full | do_pop);

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset & ~flush & do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    assign dout = mem[rd_ptr];

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, reads instruction memory, buffers words
// for decode and handles execute redirects and halt conditions.
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC   = 64'h0,
    parameter int          IMEM_BYTES = 16,
    parameter int          DEPTH      = 2
) (
    input logic                      clk,
    input logic                      reset,
    instruction_fetch_unit_if.master bus
);

    localparam int          CW    = $clog2(DEPTH + 1);
    localparam logic [64:0] LIMIT = 65'(IMEM_BYTES);
    localparam logic [64:0] SPAN1 = 65'(INST_BYTES);
    localparam logic [64:0] SPAN2 = 65'(2 * INST_BYTES);

    state_t        state;
    state_t        state_nx;
    logic [63:0]   pc;
    logic [63:0]   pc_nx;
    logic [CW-1:0] count;
    logic          valid;
    logic          pop;
    logic          push;
    logic          room;
    entry_t        head;
    entry_t        tail;

    assign valid = count != '0;
    assign pop   = valid & bus.inst_ready;
    assign room  = (count < CW'(DEPTH)) | pop;
    assign push  = (state == FETCH) & room
                 & ~bus.redirect_valid;
    assign tail  = {bus.Instruction, pc};

    fetch_buffer #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_buf (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (bus.redirect_valid),
        .din   (tail),
        .dout  (head),
        .count (count)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= FETCH;
            pc    <= RESET_PC;
        end else begin
            state <= state_nx;
            pc    <= pc_nx;
        end
    end

    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        unique case (1'b1)
            bus.redirect_valid: begin
                pc_nx = bus.redirect_pc;
                if (bus.redirect_pc[1:0] != 2'b00) begin
                    state_nx = HALT_MISALIGN;
                end else if (!fits(bus.redirect_pc, SPAN1, LIMIT)) begin
                    state_nx = HALT_END;
                end else begin
                    state_nx = FETCH;
                end
            end
            push: begin
                pc_nx = pc + 64'(INST_BYTES);
                // Stop once the following word would fall off the end
                if (!fits(pc, SPAN2, LIMIT)) begin
                    state_nx = HALT_END;
                end
            end
            default: begin
                state_nx = state;
            end
        endcase
    end

    assign bus.Inst_Address = pc;
    assign bus.inst_valid   = valid;
    assign bus.inst_out     = head.inst;
    assign bus.inst_pc      = head.pc;
    assign bus.fetch_halted = state != FETCH;
    assign bus.misaligned   = state == HALT_MISALIGN;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench: queue-based reference model compared every
// cycle, directed scenarios with literal expectations, then random.
module tb_instruction_fetch_unit;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    instruction_fetch_unit_if bus ();

    instruction_fetch_unit #(
        .RESET_PC   (64'h0),
        .IMEM_BYTES (16),
        .DEPTH      (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [31:0] words [4] = '{
        32'h02853483, 32'h009A84B3,
        32'h00148493, 32'h02953423
    };

    function automatic logic [31:0] mem_rd(input logic [63:0] a);
        if (a < 64'd16) return words[a[3:2]];
        return 32'hDEADBEEF;
    endfunction

    always_comb bus.Instruction = mem_rd(bus.Inst_Address);

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic chk(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h want %h at %0t",
                      name, act, exp, $time);
    endtask

    // Reference model: a queue of delivered-but-unconsumed words
    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t        q[$];
    logic [63:0] m_pc;
    bit          m_end;
    bit          m_mis;
    int          n;
    bit          popd;
    bit          chk_en = 0;

    always @(posedge clk) begin
        if (!reset) begin
            q.delete();
            m_pc  = 64'd0;
            m_end = 0;
            m_mis = 0;
        end else if (bus.redirect_valid) begin
            q.delete();
            m_pc  = bus.redirect_pc;
            m_mis = (m_pc[1:0] != 2'b00);
            m_end = !m_mis &&
                    (({1'b0, m_pc} + 65'd4) > 65'd16);
        end else begin
            n    = q.size();
            popd = (n > 0) && bus.inst_ready;
            if (popd) void'(q.pop_front());
            if (!m_end && !m_mis && (n < 2 || popd)) begin
                q.push_back('{m_pc, mem_rd(m_pc)});
                if (({1'b0, m_pc} + 65'd8) > 65'd16) m_end = 1;
                m_pc = m_pc + 64'd4;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("addr", bus.Inst_Address, m_pc);
            chk("valid", 64'(bus.inst_valid), 64'(q.size() != 0));
            chk("halted", 64'(bus.fetch_halted), 64'(m_end | m_mis));
            chk("misal", 64'(bus.misaligned), 64'(m_mis));
            if (q.size() != 0) begin
                chk("head_pc", bus.inst_pc, q[0].pc);
                chk("head_inst", 64'(bus.inst_out), 64'(q[0].inst));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        bus.redirect_valid = 1'b0;
        tick();
    endtask

    function automatic logic [63:0] pick_pc();
        case ($urandom_range(0, 7))
            0, 1, 2, 3: return 64'($urandom_range(0, 4) * 4);
            4:          return 64'($urandom_range(0, 7) * 4 + 2);
            5:          return 64'hFFFF_FFFF_FFFF_FFFC;
            6:          return {$urandom, $urandom};
            default:    return 64'd12;
        endcase
    endfunction

    int r;

    initial begin
        reset = 1'b0;
        bus.inst_ready = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 64'd0;
        tick();
        tick();
        chk_en = 1;
        chk("rst_valid", 64'(bus.inst_valid), 64'd0);
        chk("rst_halt", 64'(bus.fetch_halted), 64'd0);
        chk("rst_mis", 64'(bus.misaligned), 64'd0);
        chk("rst_addr", bus.Inst_Address, 64'd0);

        // Straight-line run to the end of memory
        reset = 1'b1;
        bus.inst_ready = 1'b1;
        tick();
        chk("t1_pc0", bus.inst_pc, 64'd0);
        chk("t1_in0", 64'(bus.inst_out), 64'h02853483);
        tick();
        chk("t1_pc4", bus.inst_pc, 64'd4);
        chk("t1_in4", 64'(bus.inst_out), 64'h009A84B3);
        tick();
        chk("t1_pc8", bus.inst_pc, 64'd8);
        tick();
        chk("t1_pc12", bus.inst_pc, 64'd12);
        chk("t1_in12", 64'(bus.inst_out), 64'h02953423);
        chk("t1_halt", 64'(bus.fetch_halted), 64'd1);
        tick();
        chk("t1_empty", 64'(bus.inst_valid), 64'd0);

        // Back-pressure fills the buffer
        do_reset();
        bus.inst_ready = 1'b0;
        reset = 1'b1;
        repeat (5) tick();
        chk("t2_addr", bus.Inst_Address, 64'd8);
        chk("t2_head", bus.inst_pc, 64'd0);
        bus.inst_ready = 1'b1;
        tick();
        chk("t2_pc4", bus.inst_pc, 64'd4);
        tick();
        chk("t2_pc8", bus.inst_pc, 64'd8);
        tick();
        chk("t2_pc12", bus.inst_pc, 64'd12);
        tick();

        // Redirect squashes the head
        do_reset();
        reset = 1'b1;
        tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 64'd4;
        tick();
        bus.redirect_valid = 1'b0;
        chk("t3_flush", 64'(bus.inst_valid), 64'd0);
        chk("t3_addr", bus.Inst_Address, 64'd4);
        tick();
        chk("t3_pc", bus.inst_pc, 64'd4);
        chk("t3_inst", 64'(bus.inst_out), 64'h009A84B3);

        // Misaligned redirect, then recovery
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 64'd6;
        tick();
        bus.redirect_valid = 1'b0;
        chk("t4_mis", 64'(bus.misaligned), 64'd1);
        chk("t4_halt", 64'(bus.fetch_halted), 64'd1);
        chk("t4_valid", 64'(bus.inst_valid), 64'd0);
        repeat (2) tick();
        chk("t4_hold", 64'(bus.misaligned), 64'd1);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 64'd8;
        tick();
        bus.redirect_valid = 1'b0;
        chk("t4_clr", 64'(bus.fetch_halted), 64'd0);
        tick();
        chk("t4_pc8", bus.inst_pc, 64'd8);
        chk("t4_in8", 64'(bus.inst_out), 64'h00148493);

        // Reset while full and halted at the end
        do_reset();
        bus.inst_ready = 1'b0;
        reset = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 64'd8;
        tick();
        bus.redirect_valid = 1'b0;
        tick();
        tick();
        chk("t5_halt", 64'(bus.fetch_halted), 64'd1);
        chk("t5_head", bus.inst_pc, 64'd8);
        reset = 1'b0;
        tick();
        chk("t5_valid", 64'(bus.inst_valid), 64'd0);
        chk("t5_nohalt", 64'(bus.fetch_halted), 64'd0);
        chk("t5_addr", bus.Inst_Address, 64'd0);
        reset = 1'b1;
        bus.inst_ready = 1'b1;
        tick();
        chk("t5_restart", 64'(bus.inst_out), 64'h02853483);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            bus.inst_ready = ($urandom_range(0, 3) != 0);
            bus.redirect_valid = (r < 6);
            bus.redirect_pc = pick_pc();
            reset = (r != 99);
            tick();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
